// File: rtl/conv_quadrant_address_gen_pkg.sv
// rtl/conv_quadrant_address_gen_pkg.sv - shared types, defaults and constant helpers for the conv address generator
package conv_addr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int DEF_K           = 4;
   localparam int DEF_STRIDE      = 2;
   localparam int DEF_OUT_Q_W     = 8;
   localparam int DEF_OUT_Q_H     = 8;
   localparam int DEF_NUM_VECTORS = 4;
   localparam int DEF_IMG_W       = 64;
   localparam int DEF_IN_ADDR_W   = 12;
   localparam int DEF_B_ADDR_W    = 9;

   function automatic int elems(input int k);
      return k * k;
   endfunction

   function automatic int pairs_per_quadrant(input int k, input int oqw, input int oqh, input int nv);
      return nv * oqh * oqw * k * k;
   endfunction

   // Input-image offset of the right-hand (column) and lower (row) quadrant halves.
   function automatic int col_quad_offset(input int oqw, input int stride);
      return oqw * stride;
   endfunction

   function automatic int row_quad_offset(input int oqh, input int stride, input int img_w);
      return oqh * stride * img_w;
   endfunction

   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/conv_quadrant_address_gen_wrap_counter.sv
// rtl/conv_quadrant_address_gen_wrap_counter.sv - loadable counter stepping by STEP and wrapping to 0 after MAX
module wrap_counter #(
   parameter int MAX  = 3,
   parameter int STEP = 1,
   parameter int W    = 2
) (
   input  logic         clock,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         inc,
   output logic [W-1:0] count_next,
   output logic         at_max
);

   logic [W-1:0] count;

   assign at_max = (count == W'(MAX));

   // count_next is exported so the parent can register outputs from the post-edge value.
   always_comb begin
      count_next = count;
      if (load) begin
         count_next = load_value;
      end else if (inc) begin
         count_next = at_max ? '0 : count + W'(STEP);
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         count <= '0;
      end else begin
         count <= count_next;
      end
   end

endmodule

// File: rtl/conv_quadrant_address_gen.sv
// rtl/conv_quadrant_address_gen.sv - kernel/input address walker for one conv quadrant or all four in sequence
module conv_quadrant_address_gen
   import conv_addr_pkg::*;
#(
   parameter int K           = DEF_K,
   parameter int STRIDE      = DEF_STRIDE,
   parameter int OUT_Q_W     = DEF_OUT_Q_W,
   parameter int OUT_Q_H     = DEF_OUT_Q_H,
   parameter int NUM_VECTORS = DEF_NUM_VECTORS,
   parameter int IMG_W       = DEF_IMG_W,
   parameter int IN_ADDR_W   = DEF_IN_ADDR_W,
   parameter int B_ADDR_W    = DEF_B_ADDR_W
) (
   input  logic                 clock,
   input  logic                 clear,
   input  logic                 go,
   input  logic [1:0]           quadrant,
   input  logic                 all_quadrants,
   input  logic                 addr_ready,
   output logic                 addr_valid,
   output logic [B_ADDR_W-1:0]  b_element_address,
   output logic [IN_ADDR_W-1:0] input_address,
   output logic                 last_element,
   output logic                 last_vector_pos,
   output logic [1:0]           cur_quadrant,
   output logic                 busy,
   output logic                 done
);

   localparam int ELEMS  = elems(K);
   localparam int W_KC   = cnt_w(K - 1);
   localparam int W_E    = cnt_w(ELEMS - 1);
   localparam int W_C    = cnt_w(OUT_Q_W - 1);
   localparam int W_R    = cnt_w(OUT_Q_H - 1);
   localparam int W_V    = cnt_w((NUM_VECTORS - 1) * ELEMS);
   localparam int MAX_IN = ((2 * OUT_Q_H - 1) * STRIDE + K) * IMG_W;

   localparam logic [IN_ADDR_W-1:0] ONE           = IN_ADDR_W'(1);
   localparam logic [IN_ADDR_W-1:0] KERN_ROW_STEP = IN_ADDR_W'(IMG_W - K + 1);
   localparam logic [IN_ADDR_W-1:0] COL_STEP      = IN_ADDR_W'(STRIDE);
   localparam logic [IN_ADDR_W-1:0] ROW_STEP      = IN_ADDR_W'(STRIDE * IMG_W);
   localparam logic [IN_ADDR_W-1:0] COL_Q_OFF     = IN_ADDR_W'(col_quad_offset(OUT_Q_W, STRIDE));
   localparam logic [IN_ADDR_W-1:0] ROW_Q_OFF     = IN_ADDR_W'(row_quad_offset(OUT_Q_H, STRIDE, IMG_W));
   localparam logic [W_E-1:0]       E_MAX         = W_E'(ELEMS - 1);
   localparam logic [W_C-1:0]       C_MAX         = W_C'(OUT_Q_W - 1);
   localparam logic [W_R-1:0]       R_MAX         = W_R'(OUT_Q_H - 1);

   if (MAX_IN > 2 ** IN_ADDR_W) begin : g_in_addr_check
      $error("conv_quadrant_address_gen: input address range exceeds IN_ADDR_W");
   end
   if (NUM_VECTORS * ELEMS > 2 ** B_ADDR_W) begin : g_b_addr_check
      $error("conv_quadrant_address_gen: kernel address range exceeds B_ADDR_W");
   end

   state_t state, state_n;
   logic   all_q;
   logic   start, step, e_wrap, c_wrap, r_wrap, quad_end, final_step;
   logic   valid_n, busy_n, done_n;

   logic [W_KC-1:0] kc_n;
   logic [W_E-1:0]  kr_n, e_n;
   logic [W_C-1:0]  c_n;
   logic [W_R-1:0]  r_n;
   logic [W_V-1:0]  vec_n;
   logic [1:0]      q_n;
   logic            kc_max, kr_max, c_max, r_max, v_max, q_max;

   logic [IN_ADDR_W-1:0] kern_off, col_ptr, row_ptr;
   logic [IN_ADDR_W-1:0] kern_n, col_n, row_n;
   logic                 last_element_n;

   assign start      = (state == ST_IDLE) & go;
   assign step       = addr_valid & addr_ready;
   assign e_wrap     = step & kc_max & kr_max;
   assign c_wrap     = e_wrap & c_max;
   assign r_wrap     = c_wrap & r_max;
   assign quad_end   = r_wrap & v_max;
   assign final_step = quad_end & (~all_q | q_max);

   // Kernel element is split into column (kc) and row*K (kr) so the input offset can step without a divider.
   wrap_counter #(.MAX(K - 1), .STEP(1), .W(W_KC)) u_kc (
      .clock(clock), .clear(clear), .load(start), .load_value('0),
      .inc(step), .count_next(kc_n), .at_max(kc_max)
   );

   wrap_counter #(.MAX((K - 1) * K), .STEP(K), .W(W_E)) u_kr (
      .clock(clock), .clear(clear), .load(start), .load_value('0),
      .inc(step & kc_max), .count_next(kr_n), .at_max(kr_max)
   );

   wrap_counter #(.MAX(OUT_Q_W - 1), .STEP(1), .W(W_C)) u_col (
      .clock(clock), .clear(clear), .load(start), .load_value('0),
      .inc(e_wrap), .count_next(c_n), .at_max(c_max)
   );

   wrap_counter #(.MAX(OUT_Q_H - 1), .STEP(1), .W(W_R)) u_row (
      .clock(clock), .clear(clear), .load(start), .load_value('0),
      .inc(c_wrap), .count_next(r_n), .at_max(r_max)
   );

   wrap_counter #(.MAX((NUM_VECTORS - 1) * ELEMS), .STEP(ELEMS), .W(W_V)) u_vec (
      .clock(clock), .clear(clear), .load(start), .load_value('0),
      .inc(r_wrap), .count_next(vec_n), .at_max(v_max)
   );

   wrap_counter #(.MAX(3), .STEP(1), .W(2)) u_quad (
      .clock(clock), .clear(clear), .load(start),
      .load_value(all_quadrants ? 2'd0 : quadrant),
      .inc(quad_end & all_q), .count_next(q_n), .at_max(q_max)
   );

   assign e_n            = kr_n + W_E'(kc_n);
   assign last_element_n = (e_n == E_MAX);

   // Pointer reloads pick the quadrant base from q_n so a quadrant change lands on the same edge.
   always_comb begin
      kern_n = kern_off;
      col_n  = col_ptr;
      row_n  = row_ptr;
      if (start) begin
         kern_n = '0;
         col_n  = q_n[0] ? COL_Q_OFF : '0;
         row_n  = q_n[1] ? ROW_Q_OFF : '0;
      end else begin
         if (step) begin
            if (kc_max & kr_max) begin
               kern_n = '0;
            end else if (kc_max) begin
               kern_n = kern_off + KERN_ROW_STEP;
            end else begin
               kern_n = kern_off + ONE;
            end
         end
         if (e_wrap) begin
            col_n = c_max ? (q_n[0] ? COL_Q_OFF : '0) : col_ptr + COL_STEP;
         end
         if (c_wrap) begin
            row_n = r_max ? (q_n[1] ? ROW_Q_OFF : '0) : row_ptr + ROW_STEP;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         kern_off          <= '0;
         col_ptr           <= '0;
         row_ptr           <= '0;
         all_q             <= 1'b0;
         input_address     <= '0;
         b_element_address <= '0;
         last_element      <= 1'b0;
         last_vector_pos   <= 1'b0;
         cur_quadrant      <= 2'd0;
      end else begin
         kern_off          <= kern_n;
         col_ptr           <= col_n;
         row_ptr           <= row_n;
         all_q             <= start ? all_quadrants : all_q;
         input_address     <= row_n + col_n + kern_n;
         b_element_address <= B_ADDR_W'(vec_n) + B_ADDR_W'(e_n);
         last_element      <= last_element_n;
         last_vector_pos   <= last_element_n & (c_n == C_MAX) & (r_n == R_MAX);
         cur_quadrant      <= q_n;
      end
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE: if (go) state_n = ST_RUN;
         ST_RUN:  if (final_step) state_n = ST_DONE;
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   // Valid rises one cycle after the go edge, giving the address registers a cycle to settle.
   always_comb begin
      valid_n = (state == ST_RUN) & ~final_step;
      busy_n  = (state_n == ST_RUN);
      done_n  = (state_n == ST_DONE);
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         addr_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         addr_valid <= valid_n;
         busy       <= busy_n;
         done       <= done_n;
      end
   end

endmodule

// File: tb/tb_conv_quadrant_address_gen.sv
// tb/tb_conv_quadrant_address_gen.sv - randomized self-checking bench against an arithmetic reference model
module tb_conv_quadrant_address_gen;

   localparam int K = 4, STRIDE = 2, OQW = 8, OQH = 8, NV = 4, IMG_W = 64, IAW = 12, BAW = 9;
   localparam int PPQ = NV * OQH * OQW * K * K;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic           clear, go, all_quadrants, addr_ready;
   logic [1:0]     quadrant;
   logic           addr_valid, last_element, last_vector_pos, busy, done;
   logic [BAW-1:0] b_element_address;
   logic [IAW-1:0] input_address;
   logic [1:0]     cur_quadrant;

   int         checks = 0, failures = 0;
   int         exp_idx = 0, done_cnt = 0, cur_total = PPQ;
   logic [1:0] cur_q = 2'd0;
   bit         cur_all = 1'b0, chk_en = 1'b0, held = 1'b0;
   int         hb, hi, hq;

   conv_quadrant_address_gen #(
      .K(K), .STRIDE(STRIDE), .OUT_Q_W(OQW), .OUT_Q_H(OQH), .NUM_VECTORS(NV),
      .IMG_W(IMG_W), .IN_ADDR_W(IAW), .B_ADDR_W(BAW)
   ) dut (
      .clock(clock), .clear(clear), .go(go), .quadrant(quadrant),
      .all_quadrants(all_quadrants), .addr_ready(addr_ready), .addr_valid(addr_valid),
      .b_element_address(b_element_address), .input_address(input_address),
      .last_element(last_element), .last_vector_pos(last_vector_pos),
      .cur_quadrant(cur_quadrant), .busy(busy), .done(done)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (pair %0d)", name, act, exp, exp_idx);
      end
   endtask

   // Pair idx of a run, straight from the loop nest and address formulas.
   function automatic void model(input int idx, input bit all, input logic [1:0] q,
                                 output int b, output int ia, output bit le, output bit lvp,
                                 output int qo);
      int p, e, c, r, v, row_in, col_in;
      qo = all ? (idx / PPQ) : int'(q);
      p  = idx % PPQ;
      e  = p % (K * K);
      c  = (p / (K * K)) % OQW;
      r  = (p / (K * K * OQW)) % OQH;
      v  = p / (K * K * OQW * OQH);
      row_in = ((qo / 2) * OQH + r) * STRIDE + e / K;
      col_in = ((qo % 2) * OQW + c) * STRIDE + e % K;
      ia  = (row_in * IMG_W + col_in) % (1 << IAW);
      b   = v * K * K + e;
      le  = (e == K * K - 1);
      lvp = le && (c == OQW - 1) && (r == OQH - 1);
   endfunction

   always @(negedge clock) begin
      int mb, mi, mq;
      bit mle, mlvp;
      if (chk_en) begin
         if (held) begin
            chk("hold_valid", addr_valid, 1);
            chk("hold_b", b_element_address, hb);
            chk("hold_in", input_address, hi);
            chk("hold_quad", cur_quadrant, hq);
         end
         if (addr_valid) begin
            model(exp_idx, cur_all, cur_q, mb, mi, mle, mlvp, mq);
            chk("b_addr", b_element_address, mb);
            chk("in_addr", input_address, mi);
            chk("last_element", last_element, mle);
            chk("last_vector_pos", last_vector_pos, mlvp);
            chk("cur_quadrant", cur_quadrant, mq);
            chk("busy_in_run", busy, 1);
            if (addr_ready) begin
               exp_idx++;
               held = 1'b0;
            end else begin
               held = 1'b1;
               hb = int'(b_element_address);
               hi = int'(input_address);
               hq = int'(cur_quadrant);
            end
         end else begin
            held = 1'b0;
         end
         if (done) begin
            done_cnt++;
            chk("done_at_total", exp_idx, cur_total);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic start_run(input logic [1:0] q, input bit all);
      exp_idx    = 0;
      cur_q      = q;
      cur_all    = all;
      cur_total  = all ? 4 * PPQ : PPQ;
      addr_ready = 1'b1;
      quadrant   = q;
      all_quadrants = all;
      go = 1'b1;
      tick();
      go = 1'b0;
      quadrant = ~q;
      all_quadrants = ~all;
      chk("latency_valid_low", addr_valid, 0);
      chk("latency_busy", busy, 1);
      tick();
      chk("latency_valid_high", addr_valid, 1);
   endtask

   task automatic wait_done(input bit rnd, input int go_at, input int clr_at);
      int n = 0;
      int d0 = done_cnt;
      int bubbles = 0;
      while (done_cnt == d0 && n < cur_total * 4 + 200) begin
         addr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (go_at >= 0 && exp_idx == go_at) begin
            go = 1'b1;
            quadrant = 2'd2;
            all_quadrants = 1'b1;
         end
         if (clr_at >= 0 && exp_idx >= clr_at) begin
            clear = 1'b1;
            tick();
            clear = 1'b0;
            chk("abort_valid", addr_valid, 0);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            for (int i = 0; i < 10; i++) tick();
            chk("abort_no_done", done_cnt - d0, 0);
            return;
         end
         tick();
         go = 1'b0;
         quadrant = 2'($urandom);
         all_quadrants = 1'($urandom);
         if (busy && !addr_valid) bubbles++;
         n++;
      end
      addr_ready = 1'b1;
      chk("no_bubble", bubbles, 0);
      for (int i = 0; i < 3; i++) tick();
      chk("done_once", done_cnt - d0, 1);
   endtask

   initial begin
      int mb, mi, mq;
      bit mle, mlvp;
      clear = 1'b1; go = 1'b0; quadrant = 2'd0; all_quadrants = 1'b0; addr_ready = 1'b1;

      model(5, 0, 2'd0, mb, mi, mle, mlvp, mq);
      chk("pin_p5_b", mb, 5);
      chk("pin_p5_in", mi, 65);
      model(16, 0, 2'd0, mb, mi, mle, mlvp, mq);
      chk("pin_p16_in", mi, 2);
      model(PPQ - 1, 0, 2'd0, mb, mi, mle, mlvp, mq);
      chk("pin_last_b", mb, 63);
      chk("pin_last_in", mi, 1105);
      chk("pin_last_lvp", mlvp, 1);
      model(0, 0, 2'd3, mb, mi, mle, mlvp, mq);
      chk("pin_q3_first", mi, 1040);
      model(PPQ, 1, 2'd0, mb, mi, mle, mlvp, mq);
      chk("pin_all_q1_in", mi, 16);
      chk("pin_all_q1_quad", mq, 1);
      model(2 * PPQ, 1, 2'd0, mb, mi, mle, mlvp, mq);
      chk("pin_all_q2_in", mi, 1024);

      tick();
      tick();
      chk("rst_valid", addr_valid, 0);
      chk("rst_b", b_element_address, 0);
      chk("rst_in", input_address, 0);
      chk("rst_le", last_element, 0);
      chk("rst_lvp", last_vector_pos, 0);
      chk("rst_quad", cur_quadrant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      clear = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_valid", addr_valid, 0);
      end

      chk_en = 1'b1;

      start_run(2'd0, 1'b0);
      chk("q0_first_b", b_element_address, 0);
      chk("q0_first_in", input_address, 0);
      wait_done(1'b0, -1, -1);

      start_run(2'd3, 1'b0);
      chk("q3_first_in", input_address, 1040);
      chk("q3_quad", cur_quadrant, 3);
      wait_done(1'b0, -1, -1);

      start_run(2'd2, 1'b1);
      chk("all_first_in", input_address, 0);
      chk("all_first_quad", cur_quadrant, 0);
      wait_done(1'b0, -1, -1);

      start_run(2'd2, 1'b0);
      wait_done(1'b1, -1, -1);

      start_run(2'd1, 1'b0);
      wait_done(1'b0, 50, -1);

      start_run(2'd0, 1'b0);
      wait_done(1'b0, -1, 100);

      start_run(2'd0, 1'b0);
      chk("restart_first_b", b_element_address, 0);
      chk("restart_first_in", input_address, 0);
      wait_done(1'b0, -1, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/conv_quadrant_address_gen.md
Name: conv_quadrant_address_gen

Overview:
- Parametrised first-stage address generator for the neural-net conv layer.
- Walks kernel elements, output columns, output rows and kernel vectors for one image quadrant, or for all four in sequence.
- Each step emits one B-memory (kernel) address and one input-image address.
- Sits between the layer controller (go/done) and the B/input RAM read ports. Downstream applies valid/ready backpressure.

Parameters:
- K, 4, kernel edge; elements per window = K*K
- STRIDE, 2, input pixels between adjacent output positions
- OUT_Q_W, 8, output columns per quadrant
- OUT_Q_H, 8, output rows per quadrant
- NUM_VECTORS, 4, kernel vectors per layer
- IMG_W, 64, input image row pitch in elements
- IN_ADDR_W, 12, input address width
- B_ADDR_W, 9, B address width

Ports:
- clock  in  1  system clock
- clear  in  1  synchronous active-high reset
- go  in  1  start pulse; sampled only in IDLE
- quadrant  in  2  quadrant select; bit0 = column half, bit1 = row half; latched on go
- all_quadrants  in  1  latched on go; 1 = run quadrants 0,1,2,3 in order, ignoring quadrant
- addr_ready  in  1  downstream accepts the current address pair
- addr_valid  out  1  address pair valid
- b_element_address  out  B_ADDR_W  vector*K*K + element
- input_address  out  IN_ADDR_W  input image address
- last_element  out  1  current pair is the last element of a window (accumulator flush)
- last_vector_pos  out  1  current pair is the last pair of the current vector in this quadrant
- cur_quadrant  out  2  quadrant of the current pair
- busy  out  1  high from go accept until done
- done  out  1  one-cycle pulse after the final pair is accepted

Behaviour:
- Reset (clear=1 at a clock edge):
  - All outputs go to 0; state goes to IDLE.
  - clear has priority over go/ready in the same cycle.
  - clear mid-run aborts the run with no done pulse.
- States:
  - IDLE: go=1 -> RUN. Latch quadrant and all_quadrants; zero all counters; busy=1.
  - RUN: addr_valid=1. On addr_valid & addr_ready, advance counters; if the final pair was just accepted -> DONE.
  - DONE: done=1, busy=0, addr_valid=0 for one cycle -> IDLE.
- go in RUN or DONE is ignored.
- Latency: go sampled at edge t; first pair visible with addr_valid=1 after edge t+1. Sustained throughput is 1 pair/cycle while addr_ready=1.
- Backpressure: with addr_ready=0, every output holds stable. addr_valid must not drop before acceptance.
- Loop order, innermost first:
  - element e: 0..K*K-1, with kr = e/K, kc = e%K
  - column c: 0..OUT_Q_W-1
  - row r: 0..OUT_Q_H-1
  - vector v: 0..NUM_VECTORS-1
  - quadrant: only when all_quadrants=1
- Addresses, with qr = quadrant[1] and qc = quadrant[0]:
  - row_in = (qr*OUT_Q_H + r)*STRIDE + kr
  - col_in = (qc*OUT_Q_W + c)*STRIDE + kc
  - input_address = row_in*IMG_W + col_in, truncated to IN_ADDR_W
  - b_element_address = v*K*K + e
- Implementation uses incremental base pointers (adders), no runtime multipliers. Outputs are registered.
- Flags:
  - last_element = (e == K*K-1)
  - last_vector_pos = last_element & (c == OUT_Q_W-1) & (r == OUT_Q_H-1)
- Run length:
  - one quadrant: NUM_VECTORS*OUT_Q_H*OUT_Q_W*K*K pairs (4096 at defaults)
  - all_quadrants: 4x that
  - Quadrant advance is seamless, with no bubble.
- Elaboration checks:
  - ((2*OUT_Q_H-1)*STRIDE + K)*IMG_W must fit in IN_ADDR_W
  - NUM_VECTORS*K*K must fit in B_ADDR_W

Decomposition:
- Package conv_addr_pkg holds:
  - state enum (IDLE/RUN/DONE)
  - derived constants: ELEMS = K*K, per-quadrant pair count, quadrant row/column offsets
- One natural sub-module: wrap_counter (parametrised MAX, inc, wrap flag), instanced for element, column, row, vector and quadrant.

Test Plan:
- Reset then idle: clear=1 for 2 cycles -> all outputs 0. go=0 for 10 cycles -> addr_valid stays 0.
- Quadrant 0, addr_ready=1:
  - first pair b=0/in=0
  - pair 5 b=5/in=65
  - pair 16 (c=1) in=2
  - last pair b=63/in=1105
  - 4096 accepts, then done pulse exactly once
- Quadrant 3: first input_address=1040; pair 5 = 1105; cur_quadrant=3 throughout.
- all_quadrants=1:
  - 16384 pairs total
  - cur_quadrant steps 0->1->2->3 with no bubble
  - first in of quadrant 1 = 16; of quadrant 2 = 1024
- Random addr_ready (50%): outputs stable while stalled; accepted sequence identical to the unstalled reference model.
- Abuse:
  - go during RUN -> ignored
  - clear at pair 100 -> IDLE next cycle, no done
  - new go -> restarts from pair 0
